// File: rtl/video_pattern_timing_gen_if.sv
// ---------------------------------------------------------------------------
// video_pattern_timing_gen_if
//
// Purpose:
//   Groups the free-running video output bus of video_pattern_timing_gen.
//   The bus carries sync, data enable, pixel colour, the active-area pixel
//   coordinates and a frame-start strobe. Everything is in the pixel clock
//   domain. There is no back-pressure, so the consumer must accept a word on
//   every cycle.
//
// Signals:
//   video_hs     horizontal sync (polarity set by the generator)
//   video_vs     vertical sync (polarity set by the generator)
//   video_de     data enable, high inside the active picture area
//   video_rgb    pixel colour {R[23:16], G[15:8], B[7:0]}
//   pixel_xpos   active x coordinate, 0 outside the active area
//   pixel_ypos   active y coordinate, 0 outside the active area
//   frame_start  one-cycle pulse on the first output cycle of each frame
//
// Modports:
//   master  the timing/pattern generator (drives everything)
//   slave   the encoder and overlay consumers (observe everything)
// ---------------------------------------------------------------------------
interface video_pattern_timing_gen_if #(
    parameter int CNT_W = 12
);

    logic             video_hs;
    logic             video_vs;
    logic             video_de;
    logic [23:0]      video_rgb;
    logic [CNT_W-1:0] pixel_xpos;
    logic [CNT_W-1:0] pixel_ypos;
    logic             frame_start;

    modport master (
        output video_hs,
        output video_vs,
        output video_de,
        output video_rgb,
        output pixel_xpos,
        output pixel_ypos,
        output frame_start
    );

    modport slave (
        input video_hs,
        input video_vs,
        input video_de,
        input video_rgb,
        input pixel_xpos,
        input pixel_ypos,
        input frame_start
    );

endinterface

// File: rtl/video_pattern_timing_gen.sv
// ---------------------------------------------------------------------------
// video_pattern_timing_gen
//
// Purpose:
//   Programmable video timing generator with four built-in test patterns
//   (colour bars, checkerboard, gradient, solid colour). It replaces the
//   fixed 1280x720 timing driver / colour-bar pair and feeds the RGB-to-DVI
//   encoder directly. Pixel coordinates and a frame-start strobe are also
//   exported so overlay logic can lock to the raster.
//
//   Each line runs sync, back porch, active, front porch. Each frame runs the
//   same way in lines. Every output is registered from the current counter
//   values, so all outputs share a single cycle of latency and stay
//   mutually aligned.
//
// Ports:
//   pixel_clk   in   pixel clock, the only clock
//   sys_rst_n   in   asynchronous active-low reset
//   pat_mode    in   pattern select: 0 bars, 1 checker, 2 gradient, 3 solid
//   solid_rgb   in   solid colour {R,G,B} used by pattern 3
//   vid         master modport of video_pattern_timing_gen_if (hs, vs, de,
//                    rgb, xpos, ypos, frame_start)
//
// Parameters:
//   H_ACT/H_FP/H_SYNC/H_BP   horizontal timing in pixels
//   V_ACT/V_FP/V_SYNC/V_BP   vertical timing in lines
//   HS_POL/VS_POL            1 = active-high sync, 0 = active-low sync
//   CNT_W                    counter width, must hold H_TOT-1 and V_TOT-1
//   BAR_NUM                  number of colour bars (1..8)
//   CHK_LOG2                 log2 of the checkerboard square size
// ---------------------------------------------------------------------------
module video_pattern_timing_gen #(
    parameter int H_ACT    = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACT    = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1,
    parameter int CNT_W    = 12,
    parameter int BAR_NUM  = 8,
    parameter int CHK_LOG2 = 5
) (
    input  logic                          pixel_clk,
    input  logic                          sys_rst_n,
    input  logic [1:0]                    pat_mode,
    input  logic [23:0]                   solid_rgb,
    video_pattern_timing_gen_if.master    vid
);

    // Derived raster geometry.
    localparam int H_TOT   = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOT   = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int V_START = V_SYNC + V_BP;
    localparam int BAR_W   = H_ACT / BAR_NUM;

    // Counter-width constants so every compare is width matched.
    localparam logic [CNT_W-1:0] H_LAST_C  = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST_C  = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_START_C = CNT_W'(H_START);
    localparam logic [CNT_W-1:0] H_END_C   = CNT_W'(H_START + H_ACT);
    localparam logic [CNT_W-1:0] V_START_C = CNT_W'(V_START);
    localparam logic [CNT_W-1:0] V_END_C   = CNT_W'(V_START + V_ACT);
    localparam logic [CNT_W-1:0] BAR_W_C   = CNT_W'(BAR_W);
    localparam logic [2:0]       BAR_LAST  = 3'(BAR_NUM - 1);

    // Sync output levels: active level equals the polarity bit.
    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    // Pattern select encoding.
    typedef enum logic [1:0] {
        PAT_BARS    = 2'd0,
        PAT_CHECKER = 2'd1,
        PAT_GRAD    = 2'd2,
        PAT_SOLID   = 2'd3
    } pat_e;

    // Raster counters and latched per-frame settings.
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [CNT_W-1:0] h_next;
    pat_e             mode_r;
    logic [23:0]      solid_r;

    // Colour-bar tracker state (describes the pixel at h_cnt).
    logic [2:0]       bar_idx;
    logic [CNT_W-1:0] bar_bound;
    logic [CNT_W-1:0] x_next;

    // Decoded view of the current counter position.
    logic             h_last;
    logic             v_last;
    logic             h_sync_on;
    logic             v_sync_on;
    logic             de_cur;
    logic             frame_first;
    logic [CNT_W-1:0] x_cur;
    logic [CNT_W-1:0] y_cur;
    pat_e             mode_eff;
    logic [23:0]      solid_eff;
    logic [7:0]       grad_sum;
    logic [23:0]      rgb_cur;

    // Registered outputs.
    logic             hs_q;
    logic             vs_q;
    logic             de_q;
    logic [23:0]      rgb_q;
    logic [CNT_W-1:0] xpos_q;
    logic [CNT_W-1:0] ypos_q;
    logic             fs_q;

    // Fixed colour-bar palette, brightest first and black last.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    // Decode the counter position into wrap flags, sync windows, the active
    // window and active-area coordinates. The coordinates are plain offsets
    // and are only meaningful while de_cur is high.
    always_comb begin
        h_last      = (h_cnt == H_LAST_C);
        v_last      = (v_cnt == V_LAST_C);
        h_next      = h_last ? '0 : h_cnt + 1'b1;
        x_next      = h_next - H_START_C;
        h_sync_on   = (h_cnt < H_SYNC_C);
        v_sync_on   = (v_cnt < V_SYNC_C);
        de_cur      = (h_cnt >= H_START_C) && (h_cnt < H_END_C) &&
                      (v_cnt >= V_START_C) && (v_cnt < V_END_C);
        frame_first = (h_cnt == '0) && (v_cnt == '0);
        x_cur       = h_cnt - H_START_C;
        y_cur       = v_cnt - V_START_C;
    end

    // Horizontal counter wraps every line; the vertical counter steps on the
    // horizontal wrap and wraps every frame.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_next;
            if (h_last) begin
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end
        end
    end

    // Pattern settings are sampled once per frame on the first counter
    // position, so a change mid-frame never tears the picture.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_r  <= PAT_BARS;
            solid_r <= '0;
        end else if (frame_first) begin
            mode_r  <= pat_e'(pat_mode);
            solid_r <= solid_rgb;
        end
    end

    // The cycle that latches new settings also produces an output word, so it
    // uses the incoming values directly. That only matters for rasters with
    // no sync/porch ahead of the first pixel, but it keeps the whole frame on
    // one setting.
    always_comb begin
        mode_eff  = frame_first ? pat_e'(pat_mode) : mode_r;
        solid_eff = frame_first ? solid_rgb : solid_r;
    end

    // Bar index tracking without a divider. The tracker is advanced using the
    // next counter value so that bar_idx always describes h_cnt. It restarts
    // on the first active pixel of every line and steps when x reaches the
    // next bar boundary. It stops at the last bar, which therefore absorbs
    // the H_ACT/BAR_NUM remainder. Outside the active area x_next wraps to
    // values far above any boundary, so no false steps happen there.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bar_idx   <= '0;
            bar_bound <= BAR_W_C;
        end else if (h_next == H_START_C) begin
            bar_idx   <= '0;
            bar_bound <= BAR_W_C;
        end else if ((x_next == bar_bound) && (bar_idx != BAR_LAST)) begin
            bar_idx   <= bar_idx + 3'd1;
            bar_bound <= bar_bound + BAR_W_C;
        end
    end

    // Pixel colour for the current position. Blanking forces black, so only
    // the active area ever carries pattern data.
    always_comb begin
        rgb_cur  = 24'h000000;
        grad_sum = x_cur[7:0] + y_cur[7:0];
        case (mode_eff)
            PAT_BARS:    rgb_cur = bar_colour(bar_idx);
            PAT_CHECKER: rgb_cur = (x_cur[CHK_LOG2] ^ y_cur[CHK_LOG2]) ?
                                   24'h000000 : 24'hFFFFFF;
            PAT_GRAD:    rgb_cur = {x_cur[7:0], y_cur[7:0], grad_sum};
            PAT_SOLID:   rgb_cur = solid_eff;
            default:     rgb_cur = 24'h000000;
        endcase
        if (!de_cur) begin
            rgb_cur = 24'h000000;
        end
    end

    // Output register stage. Everything is registered from the same counter
    // snapshot, which keeps sync, enable, colour, coordinates and the frame
    // strobe aligned with one cycle of latency. Reset parks the syncs at
    // their inactive level and blanks the picture.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hs_q   <= ~HS_ON;
            vs_q   <= ~VS_ON;
            de_q   <= 1'b0;
            rgb_q  <= 24'h000000;
            xpos_q <= '0;
            ypos_q <= '0;
            fs_q   <= 1'b0;
        end else begin
            hs_q   <= h_sync_on ? HS_ON : ~HS_ON;
            vs_q   <= v_sync_on ? VS_ON : ~VS_ON;
            de_q   <= de_cur;
            rgb_q  <= rgb_cur;
            xpos_q <= de_cur ? x_cur : '0;
            ypos_q <= de_cur ? y_cur : '0;
            fs_q   <= frame_first;
        end
    end

    // Drive the video bus from the output registers.
    assign vid.video_hs    = hs_q;
    assign vid.video_vs    = vs_q;
    assign vid.video_de    = de_q;
    assign vid.video_rgb   = rgb_q;
    assign vid.pixel_xpos  = xpos_q;
    assign vid.pixel_ypos  = ypos_q;
    assign vid.frame_start = fs_q;

endmodule
